// File: rtl/tausworthe_stream_gen.sv
// Combined taus88 generator with reseed, warm-up discard and valid/ready word assembly.
// Optional word/reseed statistics outputs are enabled by defining TAUS_STREAM_STATS_EN.
module tausworthe_stream_gen #(
   parameter int unsigned OUT_W  = 32,
   parameter int unsigned WARMUP = 16,
   parameter logic [31:0] SEED1  = 32'hE761B9DB,
   parameter logic [31:0] SEED2  = 32'hB4B4D15C,
   parameter logic [31:0] SEED3  = 32'hC0B4DD55
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_valid,
   input  logic [95:0]      seed_data,
   output logic             seed_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
`ifdef TAUS_STREAM_STATS_EN
   ,
   output logic [31:0]      word_count,
   output logic [15:0]      reseed_count
`endif
);

   localparam int unsigned     WORDS      = OUT_W / 32;
   localparam int              IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
   localparam logic [15:0]     WARMUP_CNT = 16'(WARMUP);

   typedef enum logic [1:0] {WARM, FILL, HOLD} state_t;

   function automatic logic [31:0] step1(input logic [31:0] s);
      logic [31:0] b;
      b = ((s << 13) ^ s) >> 19;
      return ((s & 32'hFFFFFFFE) << 12) ^ b;
   endfunction

   function automatic logic [31:0] step2(input logic [31:0] s);
      logic [31:0] b;
      b = ((s << 2) ^ s) >> 25;
      return ((s & 32'hFFFFFFF8) << 4) ^ b;
   endfunction

   function automatic logic [31:0] step3(input logic [31:0] s);
      logic [31:0] b;
      b = ((s << 3) ^ s) >> 11;
      return ((s & 32'hFFFFFFF0) << 17) ^ b;
   endfunction

   state_t            state_reg, state_next;
   logic [31:0]       s1_reg, s2_reg, s3_reg;
   logic [31:0]       s1_next, s2_next, s3_next, word;
   logic [31:0]       s1_seed, s2_seed, s3_seed;
   logic [15:0]       cnt_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic              out_valid_reg, seed_ready_reg;
   logic [OUT_W-1:0]  out_data_reg;
   wire  [OUT_W-1:0]  asm_data;
   logic              reseed, pop, out_free;
   logic              step, fill_we, transfer;

   assign s1_next = step1(s1_reg);
   assign s2_next = step2(s2_reg);
   assign s3_next = step3(s3_reg);
   assign word    = s1_next ^ s2_next ^ s3_next;

   // Degenerate components would lock the recurrence at zero; substitute the defaults.
   assign s1_seed = (seed_data[31:0]  < 32'd2)  ? SEED1 : seed_data[31:0];
   assign s2_seed = (seed_data[63:32] < 32'd8)  ? SEED2 : seed_data[63:32];
   assign s3_seed = (seed_data[95:64] < 32'd16) ? SEED3 : seed_data[95:64];

   assign reseed   = seed_valid & seed_ready_reg;
   assign pop      = out_valid_reg & out_ready;
   assign out_free = ~out_valid_reg | out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if (WARMUP_CNT == 16'd0) state_reg <= FILL;
         else                     state_reg <= WARM;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (reseed) begin
         if (WARMUP_CNT == 16'd0) state_next = FILL;
         else                     state_next = WARM;
      end else begin
         case (state_reg)
            WARM: if (en && cnt_reg <= 16'd1) state_next = FILL;
            FILL: if (fill_we && idx_reg == LAST_IDX) state_next = HOLD;
            HOLD: begin
               if (transfer) begin
                  if (fill_we && idx_reg == LAST_IDX) state_next = HOLD;
                  else                                state_next = FILL;
               end
            end
            default: state_next = WARM;
         endcase
      end
   end

   // A HOLD transfer also starts the next fill, so single-lane output sustains one word per cycle.
   always_comb begin
      step     = 1'b0;
      fill_we  = 1'b0;
      transfer = 1'b0;
      if (!reseed) begin
         case (state_reg)
            WARM: step = en;
            FILL: begin
               step    = en;
               fill_we = en;
            end
            HOLD: begin
               if (out_free) begin
                  transfer = 1'b1;
                  step     = en;
                  fill_we  = en;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_reg         <= SEED1;
         s2_reg         <= SEED2;
         s3_reg         <= SEED3;
         cnt_reg        <= WARMUP_CNT;
         idx_reg        <= '0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         seed_ready_reg <= 1'b0;
      end else begin
         seed_ready_reg <= 1'b1;
         if (reseed) begin
            s1_reg  <= s1_seed;
            s2_reg  <= s2_seed;
            s3_reg  <= s3_seed;
            cnt_reg <= WARMUP_CNT;
            idx_reg <= '0;
         end else begin
            if (step) begin
               s1_reg <= s1_next;
               s2_reg <= s2_next;
               s3_reg <= s3_next;
            end
            if (step && state_reg == WARM) cnt_reg <= cnt_reg - 16'd1;
            if (fill_we) begin
               if (idx_reg == LAST_IDX) idx_reg <= '0;
               else                     idx_reg <= idx_reg + 1'b1;
            end
         end
         if (reseed) begin
            out_valid_reg <= 1'b0;
         end else if (transfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= asm_data;
         end else if (pop) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
      logic [31:0] lane_reg;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                                        lane_reg <= '0;
         else if (fill_we && idx_reg == IDX_W'(gi))       lane_reg <= word;
      end
      assign asm_data[32*gi +: 32] = lane_reg;
   end

   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign seed_ready = seed_ready_reg;

`ifdef TAUS_STREAM_STATS_EN
   logic [31:0] word_count_reg;
   logic [15:0] reseed_count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_count_reg   <= '0;
         reseed_count_reg <= '0;
      end else begin
         if (pop) word_count_reg <= word_count_reg + 32'd1;
         if (reseed && reseed_count_reg != 16'hFFFF) reseed_count_reg <= reseed_count_reg + 16'd1;
      end
   end

   assign word_count   = word_count_reg;
   assign reseed_count = reseed_count_reg;
`endif

endmodule

// File: tb/tb_tausworthe_stream_gen.sv
// Scoreboard bench: a software taus88 model fills an expected-word queue per (re)seed epoch,
// and a negedge monitor compares every accepted output word against it.
module tb_tausworthe_stream_gen;

   localparam int OUT_W       = 64;
   localparam int WARMUP      = 3;
   localparam int WORDS       = OUT_W / 32;
   localparam int EPOCH_WORDS = 300;
   localparam logic [31:0] D1 = 32'hE761B9DB;
   localparam logic [31:0] D2 = 32'hB4B4D15C;
   localparam logic [31:0] D3 = 32'hC0B4DD55;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic             seed_valid = 1'b0;
   logic [95:0]      seed_data = '0;
   logic             out_ready = 1'b0;
   wire              seed_ready;
   wire              out_valid;
   wire  [OUT_W-1:0] out_data;
`ifdef TAUS_STREAM_STATS_EN
   wire  [31:0]      word_count;
   wire  [15:0]      reseed_count;
`endif

   tausworthe_stream_gen #(
      .OUT_W  (OUT_W),
      .WARMUP (WARMUP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .seed_valid (seed_valid),
      .seed_data  (seed_data),
      .seed_ready (seed_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
`ifdef TAUS_STREAM_STATS_EN
      ,
      .word_count   (word_count),
      .reseed_count (reseed_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int               epoch;
      logic [OUT_W-1:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          drv_epoch = 0;
   int          mon_epoch = 0;
   int          popped = 0;
   int          tb_words = 0;
   int          tb_reseeds = 0;
   logic [31:0] m1, m2, m3;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference taus88 step on the model state.
   task automatic model_word(output logic [31:0] w);
      logic [31:0] b;
      b  = ((m1 << 13) ^ m1) >> 19;
      m1 = ((m1 & 32'hFFFFFFFE) << 12) ^ b;
      b  = ((m2 << 2) ^ m2) >> 25;
      m2 = ((m2 & 32'hFFFFFFF8) << 4) ^ b;
      b  = ((m3 << 3) ^ m3) >> 11;
      m3 = ((m3 & 32'hFFFFFFF0) << 17) ^ b;
      w  = m1 ^ m2 ^ m3;
   endtask

   task automatic push_epoch(input bit use_seed, input logic [95:0] sd);
      logic [31:0]      w;
      logic [OUT_W-1:0] acc;
      exp_t             e;
      m1 = D1; m2 = D2; m3 = D3;
      if (use_seed) begin
         if (sd[31:0]  >= 32'd2)  m1 = sd[31:0];
         if (sd[63:32] >= 32'd8)  m2 = sd[63:32];
         if (sd[95:64] >= 32'd16) m3 = sd[95:64];
      end
      repeat (WARMUP) model_word(w);
      for (int k = 0; k < EPOCH_WORDS; k++) begin
         acc = '0;
         for (int j = 0; j < WORDS; j++) begin
            model_word(w);
            acc[32*j +: 32] = w;
         end
         e.epoch = drv_epoch;
         e.data  = acc;
         exp_q.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reseed(input logic [95:0] sd);
      seed_valid = 1'b1;
      seed_data  = sd;
      drv_epoch++;
      push_epoch(1'b1, sd);
      tick(1);
      seed_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         tick(1);
         n++;
      end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL %s: out_valid got 0 expected 1 within 40 cycles", name);
      end
   endtask

   // Monitor: one line per accepted word is compared against the queue head of the live epoch.
   always @(negedge clk) begin
      if (!rst) begin
         mon_epoch  = drv_epoch;
         tb_words   = 0;
         tb_reseeds = 0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].epoch < mon_epoch) void'(exp_q.pop_front());
         if (out_valid && out_ready) begin
            tb_words++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard: got word %h expected none queued", out_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("stream word", out_data, mon_e.data);
               popped++;
            end
         end
         if (seed_valid && seed_ready) begin
            tb_reseeds++;
            mon_epoch = drv_epoch;
         end
      end
   end

   initial begin
      int          lat;
      int          kind;
      logic [31:0] a, b, c;
      logic [OUT_W-1:0] hold;

      en        = 1'b1;
      out_ready = 1'b1;
      push_epoch(1'b0, '0);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset seed_ready", seed_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      lat = 0;
      for (int cyc = 1; cyc <= 30 && lat == 0; cyc++) begin
         @(posedge clk);
         #1;
         if (out_valid) lat = cyc;
      end
      check("first out_valid latency", lat, WARMUP + WORDS + 1);
      check("seed_ready after reset", seed_ready, 1);
      tick(10);

      // Back-pressure: the output word must freeze while not accepted.
      out_ready = 1'b0;
      wait_valid("stall wait");
      hold = out_data;
      for (int k = 0; k < 50; k++) begin
         tick(1);
         check("stall out_valid", out_valid, 1);
         check("stall out_data", out_data, hold);
      end
      out_ready = 1'b1;
      tick(12);

      do_reseed(96'h0);
      tick(30);
      do_reseed({32'h10, 32'h8, 32'h2});
      tick(30);

      // Reseed in the very cycle a word is popped.
      wait_valid("reseed-pop wait");
      do_reseed({32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F});
      check("out_valid after reseed+pop", out_valid, 0);
      tick(20);

      for (int k = 0; k < 300; k++) begin
         en        = ($urandom_range(99) < 70);
         out_ready = ($urandom_range(99) < 60);
         if ($urandom_range(39) == 0) begin
            kind = $urandom_range(2);
            a = $urandom; b = $urandom; c = $urandom;
            if (kind == 1) begin
               a = $urandom_range(1);
               c = $urandom_range(15);
            end else if (kind == 2) begin
               a = 32'h0; b = 32'h0; c = 32'h0;
            end
            do_reseed({c, b, a});
         end else begin
            tick(1);
         end
      end

      // Asynchronous reset mid-stream, then restart with en toggling each cycle.
      en = 1'b1;
      out_ready = 1'b1;
      tick(10);
      drv_epoch++;
      push_epoch(1'b0, '0);
      rst = 1'b0;
      #1;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset out_data", out_data, 0);
      check("mid reset seed_ready", seed_ready, 0);
      tick(2);
      rst = 1'b1;
      for (int k = 0; k < 60; k++) begin
         en = ~en;
         tick(1);
      end
      en = 1'b1;
      tick(20);

`ifdef TAUS_STREAM_STATS_EN
      check("word_count", word_count, tb_words);
      check("reseed_count", reseed_count, tb_reseeds);
`endif
      checks++;
      if (popped <= 20) begin
         errors++;
         $display("FAIL word volume: got %0d popped words expected more than 20", popped);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tausworthe_stream_gen.md
Name: tausworthe_stream_gen

Overview:
- Next-generation combined Tausworthe generator (taus88 recurrence, three 32-bit components XOR-combined).
- Adds run-time reseed, a warm-up discard phase after every (re)seed, and a step enable.
- Assembles 1..8 successive 32-bit words into a parametrised-width output word.
- Output uses a valid/ready handshake so consumers (noise injectors, test-pattern sources) can back-pressure it.

Parameters:
- OUT_W, 32, output width in bits; must be a multiple of 32, range 32..256; WORDS = OUT_W/32.
- WARMUP, 16, generator steps discarded after reset/reseed; range 0..65535.
- SEED1, 32'hE761B9DB, reset seed of component 1.
- SEED2, 32'hB4B4D15C, reset seed of component 2.
- SEED3, 32'hC0B4DD55, reset seed of component 3.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  step enable; no generator step occurs while low.
- seed_valid  in  1  reseed request.
- seed_data  in  96  {s3, s2, s1}; s1 is in [31:0].
- seed_ready  out  1  reseed accepted when seed_valid & seed_ready; constant 1 after reset release.
- out_valid  out  1  out_data holds a complete word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  assembled random word.

Behaviour:
- Recurrence per step, all 32-bit, shifts logical:
  - b = ((s1<<13)^s1)>>19; s1' = ((s1&32'hFFFFFFFE)<<12)^b.
  - b = ((s2<<2)^s2)>>25; s2' = ((s2&32'hFFFFFFF8)<<4)^b.
  - b = ((s3<<3)^s3)>>11; s3' = ((s3&32'hFFFFFFF0)<<17)^b.
  - word = s1'^s2'^s3'.
- Seed legality: s1 < 2, s2 < 8 or s3 < 16 is degenerate. Each degenerate component is replaced by its SEED parameter. Non-degenerate components are loaded unchanged.
- Reset (rst low):
  - Components load SEED1..3; warm-up counter = WARMUP; word index = 0; assembly register = 0.
  - out_valid = 0; out_data = 0; seed_ready = 0; FSM = WARM.
- FSM WARM: each cycle with en=1, one step is taken, the word is discarded and the counter decrements. At count 0 (or WARMUP=0) go to FILL.
- FSM FILL:
  - Each cycle with en=1, one step is taken and the word is written to lane [32*idx +: 32]. The first word lands in the LSB lane.
  - idx wraps WORDS-1 -> 0. Assembly is complete when lane WORDS-1 is written; go to HOLD.
- FSM HOLD:
  - If the output register is empty, or popped this cycle (out_valid&out_ready), transfer assembly -> out_data and set out_valid next cycle.
  - In that same cycle, if en=1, FILL's first step is also taken, so WORDS=1 with en=1 and out_ready=1 delivers one word per cycle.
  - If the output register is full and not popped, hold with no stepping.
- out_data/out_valid are registered, with no combinational path from out_ready. out_data is stable while out_valid=1 and out_ready=0.
- Latency from reset release with en=1 and out_ready=1: first out_valid at cycle WARMUP+WORDS+1.
- Reseed (seed_valid=1 accepted in any state):
  - Components load the checked seed; counter = WARMUP; idx = 0; go to WARM.
  - out_valid is cleared next cycle and the partial assembly is discarded.
  - Reseed wins over a step in the same cycle.
- Pop in the same cycle as reseed: the transfer counts as completed, then out_valid clears.
- en=0: the state holds. An already-valid output can still be popped.
- Reset mid-operation overrides everything immediately (asynchronous).

Optional Feature:
- Macro TAUS_STREAM_STATS_EN.
- Defined:
  - Adds outputs word_count [31:0] and reseed_count [15:0], both reset to 0.
  - word_count increments on each out_valid&out_ready and wraps at 2^32.
  - reseed_count increments on each accepted reseed and saturates at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- OUT_W=32, WARMUP=0, en=1, out_ready=1 after reset -> out_valid=1 at cycle 2. Each word equals the software taus88 model from seeds E761B9DB/B4B4D15C/C0B4DD55, one per cycle.
- OUT_W=128, WARMUP=16, out_ready=1 -> first out_valid at cycle 21. out_data[31:0] = model word 17, out_data[127:96] = model word 20.
- OUT_W=64, out_ready=0 for 50 cycles -> out_valid stays 1, out_data unchanged, exactly 2 steps after assembly complete. Raise out_ready -> next word = model words 3,4 past the first.
- Mid-FILL reseed with seed_data=96'h0 -> output stream after warm-up is identical to the post-reset stream. With {32'h10, 32'h8, 32'h2}, the stream matches the model seeded 2/8/16.
- Reseed and pop in the same cycle -> popped word counted (word_count+1 with TAUS_STREAM_STATS_EN), out_valid=0 next cycle, reseed_count=1.
- Toggle en 1/0 per cycle, WORDS=1, WARMUP=0 -> one word per two cycles, sequence equals the model. rst low mid-stream -> out_valid=0 immediately, stream restarts from word 1.
